pipe_stage_buffer: RTL and testbench

Parametrised pipeline stage register, the generalised successor to the fixed Decode/Execute buffer. It carries an arbitrary-width control bundle and data bundle between any two datapath stages. It adds a valid/ready handshake, stall, and flush with bubble insertion, plus an optional 2-entry skid mode that makes upstream `ready_o` a registered signal. One instance sits between each pair of pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_stage_buffer_if.sv | 27 ++
 rtl/pipe_stage_buffer.sv | 133 +++++++++++++
 tb/tb_pipe_stage_buffer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_buffer_if.sv
// Handshake/bus bundle between two pipeline stages.
// master = upstream/downstream environment, slave = the stage buffer.
interface pipe_stage_buffer_if #(
  parameter int CTRL_W = 12,
  parameter int DATA_W = 149
);
  logic              flush_i;
  logic              valid_i;
  logic              ready_o;
  logic [CTRL_W-1:0] ctrl_i;
  logic [DATA_W-1:0] data_i;
  logic              valid_o;
  logic              ready_i;
  logic [CTRL_W-1:0] ctrl_o;
  logic [DATA_W-1:0] data_o;
  logic [1:0]        count_o;

  modport master (
    output flush_i, valid_i, ctrl_i, data_i, ready_i,
    input  ready_o, valid_o, ctrl_o, data_o, count_o
  );

  modport slave (
    input  flush_i, valid_i, ctrl_i, data_i, ready_i,
    output ready_o, valid_o, ctrl_o, data_o, count_o
  );
endinterface

// File: rtl/pipe_stage_buffer.sv
// Pipeline stage register with valid/ready handshake, flush with bubble
// insertion and an optional 2-entry skid buffer (registered ready_o).
// CTRL_W/DATA_W must match the widths of the connected interface instance.
module pipe_stage_buffer #(
  parameter int CTRL_W  = 12,
  parameter int DATA_W  = 149,
  parameter bit SKID_EN = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  pipe_stage_buffer_if.slave bus
);

  // Main register: always drives the downstream outputs.
  logic              mainValid;
  logic [CTRL_W-1:0] mainCtrl;
  logic [DATA_W-1:0] mainData;

  logic acc;  // upstream handshake completes this cycle
  logic rel;  // downstream handshake completes this cycle

  assign acc = bus.valid_i & bus.ready_o;
  assign rel = mainValid & bus.ready_i;

  assign bus.valid_o = mainValid;
  assign bus.ctrl_o  = mainCtrl;
  assign bus.data_o  = mainData;

  generate
    if (SKID_EN) begin : genSkid
      // State doubles as the occupancy count; Two means the skid slot is full.
      typedef enum logic [1:0] {
        Empty = 2'd0,
        One   = 2'd1,
        Two   = 2'd2
      } state_t;

      state_t            state;
      logic              readyQ;   // kept equal to "skid slot empty"
      logic [CTRL_W-1:0] skidCtrl;
      logic [DATA_W-1:0] skidData;

      // ready_o comes straight from a flop, so ready_i never reaches it.
      assign bus.ready_o = readyQ;
      assign bus.count_o = state;

      // Occupancy FSM moving entries between input, skid and main registers.
      always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
          state     <= Empty;
          readyQ    <= 1'b1;
          mainValid <= 1'b0;
          mainCtrl  <= '0;
          mainData  <= '0;
          skidCtrl  <= '0;
          skidData  <= '0;
        end else if (bus.flush_i) begin
          // Drop everything, including an entry offered this cycle; data is held.
          state     <= Empty;
          readyQ    <= 1'b1;
          mainValid <= 1'b0;
          mainCtrl  <= '0;
        end else begin
          case (state)
            Empty: begin
              if (acc) begin
                mainValid <= 1'b1;
                mainCtrl  <= bus.ctrl_i;
                mainData  <= bus.data_i;
                state     <= One;
              end
            end
            One: begin
              if (acc && rel) begin
                mainCtrl <= bus.ctrl_i;
                mainData <= bus.data_i;
              end else if (acc) begin
                // Downstream stalled: park the new entry behind the main one.
                skidCtrl <= bus.ctrl_i;
                skidData <= bus.data_i;
                state    <= Two;
                readyQ   <= 1'b0;
              end else if (rel) begin
                // Entry left with nothing behind it: insert an inert bubble.
                mainValid <= 1'b0;
                mainCtrl  <= '0;
                state     <= Empty;
              end
            end
            Two: begin
              if (rel) begin
                mainCtrl <= skidCtrl;
                mainData <= skidData;
                state    <= One;
                readyQ   <= 1'b1;
              end
            end
            default: begin
              state     <= Empty;
              readyQ    <= 1'b1;
              mainValid <= 1'b0;
              mainCtrl  <= '0;
            end
          endcase
        end
      end
    end else begin : genDirect
      // Accept whenever the held entry leaves this cycle or there is none.
      assign bus.ready_o = bus.ready_i | ~mainValid;
      assign bus.count_o = {1'b0, mainValid};

      // Single register: load on accept, bubble when the entry leaves unreplaced.
      always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
          mainValid <= 1'b0;
          mainCtrl  <= '0;
          mainData  <= '0;
        end else if (bus.flush_i) begin
          mainValid <= 1'b0;
          mainCtrl  <= '0;
        end else if (acc) begin
          mainValid <= 1'b1;
          mainCtrl  <= bus.ctrl_i;
          mainData  <= bus.data_i;
        end else if (rel) begin
          mainValid <= 1'b0;
          mainCtrl  <= '0;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Bench for pipe_stage_buffer: a skid instance and a direct instance run
// side by side against a queue-based reference model.
module tb_pipe_stage_buffer;
  localparam int CW = 12;
  localparam int DW = 149;

  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
  } entry_t;

  logic clk = 1'b0;
  logic rstN;
  always #5 clk = ~clk;

  pipe_stage_buffer_if #(.CTRL_W(CW), .DATA_W(DW)) busS ();
  pipe_stage_buffer_if #(.CTRL_W(CW), .DATA_W(DW)) busN ();

  pipe_stage_buffer #(.CTRL_W(CW), .DATA_W(DW), .SKID_EN(1'b1)) dutSkid (
    .clk_i(clk), .rst_ni(rstN), .bus(busS)
  );
  pipe_stage_buffer #(.CTRL_W(CW), .DATA_W(DW), .SKID_EN(1'b0)) dutDirect (
    .clk_i(clk), .rst_ni(rstN), .bus(busN)
  );

  // index 0 = skid instance, 1 = direct instance
  logic          flushV [2];
  logic          validV [2];
  logic          readyV [2];
  logic [CW-1:0] ctrlV  [2];
  logic [DW-1:0] dataV  [2];
  logic          pend   [2];
  logic [CW-1:0] pendCtrl [2];
  logic [DW-1:0] pendData [2];

  entry_t        q [2][$];
  logic [DW-1:0] held [2];
  logic          known = 1'b0;

  int total = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic string nm(input int d, input string s);
    return $sformatf("%s_%s", (d == 0) ? "skid" : "direct", s);
  endfunction

  // Capacity 2 with skid; otherwise one entry, freed by a same-cycle release.
  function automatic logic modelReady(input int d);
    if (d == 0) return q[d].size() < 2;
    return readyV[d] || (q[d].size() == 0);
  endfunction

  task automatic checkDut(input int d, input logic v, input logic [CW-1:0] c,
                          input logic [DW-1:0] dd, input logic [1:0] cnt);
    logic [CW-1:0] expC;
    expC = (q[d].size() > 0) ? q[d][0].ctrl : '0;
    check(nm(d, "valid_o"), 160'(v), 160'(q[d].size() > 0));
    check(nm(d, "ctrl_o"), 160'(c), 160'(expC));
    check(nm(d, "data_o"), 160'(dd), 160'(held[d]));
    check(nm(d, "count_o"), 160'(cnt), 160'(q[d].size()));
  endtask

  task automatic cycle();
    logic acc [2];
    logic rel [2];
    for (int d = 0; d < 2; d++) begin
      // Upstream keeps an unaccepted offer stable.
      if (pend[d]) begin
        validV[d] = 1'b1;
        ctrlV[d]  = pendCtrl[d];
        dataV[d]  = pendData[d];
      end
    end
    busS.flush_i = flushV[0]; busS.valid_i = validV[0]; busS.ready_i = readyV[0];
    busS.ctrl_i  = ctrlV[0];  busS.data_i  = dataV[0];
    busN.flush_i = flushV[1]; busN.valid_i = validV[1]; busN.ready_i = readyV[1];
    busN.ctrl_i  = ctrlV[1];  busN.data_i  = dataV[1];
    #1;
    if (known) begin
      check(nm(0, "ready_o"), 160'(busS.ready_o), 160'(modelReady(0)));
      check(nm(1, "ready_o"), 160'(busN.ready_o), 160'(modelReady(1)));
    end
    for (int d = 0; d < 2; d++) begin
      acc[d] = validV[d] && modelReady(d);
      rel[d] = (q[d].size() > 0) && readyV[d];
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      if (!rstN) begin
        q[d].delete();
        held[d] = '0;
        pend[d] = 1'b0;
      end else if (flushV[d]) begin
        q[d].delete();
        pend[d] = 1'b0;
      end else begin
        pend[d]     = validV[d] && !acc[d];
        pendCtrl[d] = ctrlV[d];
        pendData[d] = dataV[d];
        if (rel[d]) void'(q[d].pop_front());
        if (acc[d]) q[d].push_back('{ctrl: ctrlV[d], data: dataV[d]});
        if (q[d].size() > 0) held[d] = q[d][0].data;
      end
    end
    if (!rstN) known = 1'b1;
    if (known) begin
      checkDut(0, busS.valid_o, busS.ctrl_o, busS.data_o, busS.count_o);
      checkDut(1, busN.valid_o, busN.ctrl_o, busN.data_o, busN.count_o);
    end
  endtask

  // Same directed inputs to both instances, then one clock.
  task automatic drive(input logic f, input logic v, input logic r,
                       input logic [CW-1:0] c, input logic [DW-1:0] dd);
    for (int d = 0; d < 2; d++) begin
      flushV[d] = f; validV[d] = v; readyV[d] = r; ctrlV[d] = c; dataV[d] = dd;
    end
    cycle();
  endtask

  task automatic randomStim();
    logic [159:0] r;
    rstN = ($urandom_range(0, 199) != 0);
    for (int d = 0; d < 2; d++) begin
      r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      flushV[d] = ($urandom_range(0, 39) == 0);
      validV[d] = ($urandom_range(0, 3) != 0);
      readyV[d] = ($urandom_range(0, 2) != 0);
      ctrlV[d]  = CW'($urandom());
      dataV[d]  = r[DW-1:0];
    end
  endtask

  initial begin
    pend[0] = 1'b0; pend[1] = 1'b0;
    rstN = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    rstN = 1'b1;

    // Stream 1..5 at full throughput
    for (int i = 1; i <= 5; i++) drive(1'b0, 1'b1, 1'b1, CW'(i), DW'(i));
    drive(1'b0, 1'b0, 1'b1, '0, '0);

    // Stall with A, B in flight, then release
    drive(1'b0, 1'b1, 1'b0, CW'(10), DW'(10));
    drive(1'b0, 1'b1, 1'b0, CW'(11), DW'(11));
    repeat (3) drive(1'b0, 1'b0, 1'b0, '0, '0);
    check("skid_stall_count", 160'(busS.count_o), 160'(2));
    check("skid_stall_data", 160'(busS.data_o), 160'(10));
    repeat (4) drive(1'b0, 1'b0, 1'b1, '0, '0);

    // Flush mid-stall together with an offered entry C
    drive(1'b0, 1'b1, 1'b0, CW'(20), DW'(20));
    drive(1'b0, 1'b1, 1'b0, CW'(21), DW'(21));
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b1, 1'b0, CW'(22), DW'(22));
    check("skid_flush_ready", 160'(busS.ready_o), 160'(1));
    repeat (3) drive(1'b0, 1'b0, 1'b1, '0, '0);

    // Bubble zeroing of ctrl
    drive(1'b0, 1'b1, 1'b1, CW'(12'hFFF), DW'(12'h123));
    drive(1'b0, 1'b0, 1'b1, '0, '0);
    drive(1'b0, 1'b0, 1'b1, '0, '0);

    // Reset while holding two entries
    drive(1'b0, 1'b1, 1'b0, CW'(30), DW'(30));
    drive(1'b0, 1'b1, 1'b0, CW'(31), DW'(31));
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    rstN = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    rstN = 1'b1;
    repeat (3) drive(1'b0, 1'b0, 1'b1, '0, '0);

    // Randomized traffic
    repeat (600) begin
      randomStim();
      cycle();
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
